// File: rtl/serial_command_decoder.sv
// serial_command_decoder
// Turns ASCII command bytes from the USART receiver into recorder and dumper
// controls. Each command gets a one-byte acknowledge ('+' or '?') on the TX side.
// Only one response is outstanding at a time, so the receiver is stalled while
// it waits for the TX FIFO to take the byte.
module serial_command_decoder #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RESET_CYCLES   = 16
) (
  input  logic       comm_clock,
  input  logic       reset,
  input  logic       rx_valid,
  output logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       dump_busy,
  output logic       dump_start,
  output logic       record_start,
  output logic       record_trigger,
  output logic [7:0] record_limit,
  output logic       bus_reset
);

  // Width of the hex-entry timeout counter; it only ever has to hold TIMEOUT_CYCLES-1.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Width of the bus reset down-counter; it is loaded with RESET_CYCLES.
  localparam int RW = (RESET_CYCLES > 0) ? $clog2(RESET_CYCLES + 1) : 1;

  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RESET_CYCLES);

  // ASCII codes for the command bytes.
  localparam logic [7:0] CH_D     = 8'h64;  // 'd'
  localparam logic [7:0] CH_R     = 8'h72;  // 'r'
  localparam logic [7:0] CH_S     = 8'h73;  // 's'
  localparam logic [7:0] CH_T     = 8'h74;  // 't'
  localparam logic [7:0] CH_X     = 8'h78;  // 'x'
  localparam logic [7:0] CH_N     = 8'h6E;  // 'n'
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] RESP_OK  = 8'h2B;  // '+'
  localparam logic [7:0] RESP_ERR = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEX_HI  = 2'd1,
    HEX_LO  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic            rx_ready_reg;
  logic            rx_ready_next;
  logic            tx_valid_reg, tx_valid_next;
  logic [7:0]      tx_data_reg, tx_data_next;
  logic            dump_start_reg, dump_start_next;
  logic            record_start_reg, record_start_next;
  logic            record_trigger_reg, record_trigger_next;
  logic [7:0]      record_limit_reg, record_limit_next;
  logic [3:0]      hi_nibble_reg, hi_nibble_next;
  logic [TW-1:0]   timeout_cnt_reg, timeout_cnt_next;
  logic [RW-1:0]   rst_cnt_reg;
  logic            bus_reset_reg;
  logic            load_reset;

  logic            accept;
  logic            resp_go;
  logic [7:0]      resp_byte;
  logic [4:0]      hex_dec;

  // Returns {valid, nibble} for an ASCII hex digit in either letter case.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39) begin
      r = {1'b1, b[3:0]};
    end else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46)) begin
      r = {1'b1, 4'(b[3:0] + 4'd9)};
    end
    return r;
  endfunction

  assign accept  = rx_valid && rx_ready_reg;
  assign hex_dec = hex_decode(rx_data);

  // Next-state and next-output decode; every register value is computed here.
  always_comb begin
    state_next          = state_reg;
    tx_valid_next       = tx_valid_reg;
    tx_data_next        = tx_data_reg;
    dump_start_next     = 1'b0;
    record_start_next   = record_start_reg;
    record_trigger_next = 1'b0;
    record_limit_next   = record_limit_reg;
    hi_nibble_next      = hi_nibble_reg;
    timeout_cnt_next    = timeout_cnt_reg;
    load_reset          = 1'b0;
    resp_go             = 1'b0;
    resp_byte           = RESP_OK;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (rx_data)
            CH_D: begin
              resp_go = 1'b1;
              if (!dump_busy) begin
                dump_start_next = 1'b1;
              end else begin
                resp_byte = RESP_ERR;
              end
            end
            CH_R: begin
              record_start_next = 1'b1;
              resp_go           = 1'b1;
            end
            CH_S: begin
              record_start_next = 1'b0;
              resp_go           = 1'b1;
            end
            CH_T: begin
              record_trigger_next = 1'b1;
              resp_go             = 1'b1;
            end
            CH_X: begin
              load_reset = 1'b1;
              resp_go    = 1'b1;
            end
            CH_N: begin
              state_next       = HEX_HI;
              timeout_cnt_next = '0;
            end
            CH_CR, CH_LF, CH_SP: begin
              // Whitespace between commands is dropped without a reply.
            end
            default: begin
              resp_go   = 1'b1;
              resp_byte = RESP_ERR;
            end
          endcase
        end
      end

      HEX_HI, HEX_LO: begin
        if (accept) begin
          timeout_cnt_next = '0;
          if (!hex_dec[4]) begin
            resp_go   = 1'b1;
            resp_byte = RESP_ERR;
          end else if (state_reg == HEX_HI) begin
            hi_nibble_next = hex_dec[3:0];
            state_next     = HEX_LO;
          end else begin
            record_limit_next = {hi_nibble_reg, hex_dec[3:0]};
            resp_go           = 1'b1;
          end
        end else if (timeout_cnt_reg == TO_LAST) begin
          resp_go   = 1'b1;
          resp_byte = RESP_ERR;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
        end
      end

      RESPOND: begin
        if (tx_ready) begin
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (resp_go) begin
      state_next    = RESPOND;
      tx_valid_next = 1'b1;
      tx_data_next  = resp_byte;
    end

    rx_ready_next = (state_next != RESPOND);
  end

  // State and registered outputs.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      state_reg          <= IDLE;
      rx_ready_reg       <= 1'b0;
      tx_valid_reg       <= 1'b0;
      tx_data_reg        <= 8'h00;
      dump_start_reg     <= 1'b0;
      record_start_reg   <= 1'b1;
      record_trigger_reg <= 1'b0;
      record_limit_reg   <= 8'h00;
      hi_nibble_reg      <= 4'h0;
      timeout_cnt_reg    <= '0;
    end else begin
      state_reg          <= state_next;
      rx_ready_reg       <= rx_ready_next;
      tx_valid_reg       <= tx_valid_next;
      tx_data_reg        <= tx_data_next;
      dump_start_reg     <= dump_start_next;
      record_start_reg   <= record_start_next;
      record_trigger_reg <= record_trigger_next;
      record_limit_reg   <= record_limit_next;
      hi_nibble_reg      <= hi_nibble_next;
      timeout_cnt_reg    <= timeout_cnt_next;
    end
  end

  // Bus reset pulse stretcher; independent of the command FSM, reloaded by every 'x'.
  always_ff @(posedge comm_clock) begin
    if (reset) begin
      rst_cnt_reg   <= '0;
      bus_reset_reg <= 1'b0;
    end else if (load_reset) begin
      rst_cnt_reg   <= RST_LOAD;
      bus_reset_reg <= 1'b1;
    end else if (rst_cnt_reg > RW'(1)) begin
      rst_cnt_reg   <= rst_cnt_reg - 1'b1;
      bus_reset_reg <= 1'b1;
    end else begin
      rst_cnt_reg   <= '0;
      bus_reset_reg <= 1'b0;
    end
  end

  assign rx_ready       = rx_ready_reg;
  assign tx_valid       = tx_valid_reg;
  assign tx_data        = tx_data_reg;
  assign dump_start     = dump_start_reg;
  assign record_start   = record_start_reg;
  assign record_trigger = record_trigger_reg;
  assign record_limit   = record_limit_reg;
  assign bus_reset      = bus_reset_reg;

endmodule

// File: tb/tb_serial_command_decoder.sv
// Directed bench for serial_command_decoder: expected TX bytes are queued when a
// command is driven and popped when the decoder hands a byte to the TX side.
module tb_serial_command_decoder;

  localparam int TO = 20;
  localparam int RC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       dump_busy = 1'b0;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       dump_start;
  logic       record_start;
  logic       record_trigger;
  logic [7:0] record_limit;
  logic       bus_reset;

  serial_command_decoder #(
    .TIMEOUT_CYCLES(TO),
    .RESET_CYCLES  (RC)
  ) dut (
    .comm_clock    (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .dump_busy     (dump_busy),
    .dump_start    (dump_start),
    .record_start  (record_start),
    .record_trigger(record_trigger),
    .record_limit  (record_limit),
    .bus_reset     (bus_reset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int br_cnt = 0;
  always @(negedge clk) if (bus_reset) br_cnt <= br_cnt + 1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         last_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one byte; returns one cycle after acceptance (cycle N+1).
  task automatic send(input logic [7:0] b, input bit has_resp, input logic [7:0] resp);
    int w;
    w = 0;
    @(negedge clk);
    while (!rx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("rx_ready_for_0x%02h", b), {31'd0, rx_ready}, 32'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    if (has_resp) exp_q.push_back(resp);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    last_acc = cyc;
    $display("send 0x%02h accepted, cycle %0d", b, cyc);
  endtask

  // Wait (bounded) for a TX handshake and compare against the queue head.
  task automatic drain(input int bound);
    int w;
    logic [7:0] e;
    w = 0;
    while (!(tx_valid && tx_ready) && w < bound) begin
      tick();
      w++;
    end
    check("tx_handshake_seen", {31'd0, tx_valid && tx_ready}, 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check("tx_byte", {24'd0, tx_data}, {24'd0, e});
    $display("tx byte 0x%02h (expected 0x%02h), cycle %0d", tx_data, e, cyc);
    tick();
  endtask

  initial begin
    int a1, a2, b0, w, fall;
    bit stable;

    // Reset values.
    repeat (3) tick();
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_record_start", {31'd0, record_start}, 32'd1);
    check("rst_record_limit", {24'd0, record_limit}, 32'h00);
    check("rst_bus_reset", {31'd0, bus_reset}, 32'd0);
    check("rst_pulses", {30'd0, dump_start, record_trigger}, 32'd0);
    reset    = 1'b0;
    tx_ready = 1'b1;

    // r, s, t
    send(8'h72, 1'b1, 8'h2B);
    check("r_record_start", {31'd0, record_start}, 32'd1);
    drain(10);
    send(8'h73, 1'b1, 8'h2B);
    check("s_record_start", {31'd0, record_start}, 32'd0);
    drain(10);
    send(8'h74, 1'b1, 8'h2B);
    check("t_trigger_hi", {31'd0, record_trigger}, 32'd1);
    drain(10);
    check("t_trigger_lo", {31'd0, record_trigger}, 32'd0);

    // d idle / d busy
    send(8'h64, 1'b1, 8'h2B);
    check("d_pulse_hi", {31'd0, dump_start}, 32'd1);
    drain(10);
    check("d_pulse_lo", {31'd0, dump_start}, 32'd0);
    dump_busy = 1'b1;
    send(8'h64, 1'b1, 8'h3F);
    check("d_busy_no_pulse", {31'd0, dump_start}, 32'd0);
    dump_busy = 1'b0;
    drain(10);

    // Unknown byte
    send(8'h51, 1'b1, 8'h3F);
    drain(10);

    // n 3 F, then n g
    send(8'h6E, 1'b0, 8'h00);
    check("n_no_tx", {31'd0, tx_valid}, 32'd0);
    send(8'h33, 1'b0, 8'h00);
    check("hi_no_tx", {31'd0, tx_valid}, 32'd0);
    send(8'h46, 1'b1, 8'h2B);
    check("limit_3f", {24'd0, record_limit}, 32'h3F);
    drain(10);
    send(8'h6E, 1'b0, 8'h00);
    send(8'h67, 1'b1, 8'h3F);
    drain(10);
    check("limit_kept_bad_hex", {24'd0, record_limit}, 32'h3F);

    // n A then timeout
    send(8'h6E, 1'b0, 8'h00);
    send(8'h41, 1'b0, 8'h00);
    exp_q.push_back(8'h3F);
    w = 0;
    while (!tx_valid && w < 3 * TO) begin
      tick();
      w++;
    end
    check("timeout_latency", w, TO);
    drain(5);
    check("limit_kept_timeout", {24'd0, record_limit}, 32'h3F);
    check("idle_after_timeout", {31'd0, rx_ready}, 32'd1);

    // x, CR, LF, x reload 10 cycles later
    b0 = br_cnt;
    send(8'h78, 1'b1, 8'h2B);
    a1 = last_acc;
    check("x_bus_reset_rise", {31'd0, bus_reset}, 32'd1);
    drain(10);
    send(8'h0D, 1'b0, 8'h00);
    check("cr_no_tx", {31'd0, tx_valid}, 32'd0);
    send(8'h0A, 1'b0, 8'h00);
    check("lf_no_tx", {31'd0, tx_valid}, 32'd0);
    while (cyc < a1 + 9) tick();
    send(8'h78, 1'b1, 8'h2B);
    a2 = last_acc;
    drain(10);
    w = 0;
    while (bus_reset && w < 100) begin
      tick();
      w++;
    end
    fall = cyc;
    check("bus_reset_fall", fall, a2 + RC);
    check("bus_reset_total", br_cnt - b0, (a2 - a1) + RC);

    // Stalled response, then reset mid-wait
    tx_ready = 1'b0;
    send(8'h74, 1'b1, 8'h2B);
    stable = 1'b1;
    repeat (50) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'h2B && rx_ready === 1'b0)) stable = 1'b0;
      tick();
    end
    check("hold_stable", {31'd0, stable}, 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("midrst_record_start", {31'd0, record_start}, 32'd1);
    check("midrst_record_limit", {24'd0, record_limit}, 32'h00);
    check("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
    exp_q.delete();
    $display("reset during pending response, cycle %0d", cyc);
    reset    = 1'b0;
    tx_ready = 1'b1;

    // Reset cuts bus_reset short
    send(8'h78, 1'b1, 8'h2B);
    check("x2_bus_reset_rise", {31'd0, bus_reset}, 32'd1);
    drain(10);
    tick();
    reset = 1'b1;
    tick();
    check("rst_cuts_bus_reset", {31'd0, bus_reset}, 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("bus_reset_stays_low", {31'd0, bus_reset}, 32'd0);

    // Normal operation after reset
    send(8'h73, 1'b1, 8'h2B);
    check("post_rst_s", {31'd0, record_start}, 32'd0);
    drain(10);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_command_decoder.md
# serial_command_decoder

Byte-level command interpreter for the serial bus debugger. Sits between the USART receiver and the capture and dump engines in the `comm_clock` domain. It consumes ASCII command bytes and drives the recorder/dumper controls (`record_start`, `record_trigger`, `dump_start`, record limit, bus-side reset request). It also emits a one-byte acknowledge per command toward the TX FIFO.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed between hex digits of an `n` command before abort.
- `RESET_CYCLES`, default 16: length of the `bus_reset` assertion, in cycles.

Ports:
- `comm_clock`, in, 1: sole clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `rx_valid`, in, 1: command byte available from the receiver.
- `rx_ready`, out, 1: decoder accepts the byte this cycle.
- `rx_data`, in, 8: ASCII command byte.
- `tx_valid`, out, 1: response byte valid.
- `tx_ready`, in, 1: TX FIFO accepts the response.
- `tx_data`, out, 8: response byte: `+` (0x2B) or `?` (0x3F).
- `dump_busy`, in, 1: dumper is currently streaming.
- `dump_start`, out, 1: one-cycle pulse that starts a dump.
- `record_start`, out, 1: level signal; recorder armed while high.
- `record_trigger`, out, 1: one-cycle trigger pulse.
- `record_limit`, out, 8: maximum record count; 0 means unlimited.
- `bus_reset`, out, 1: reset request, held for `RESET_CYCLES` cycles.

## Operation
- States: IDLE, HEX_HI, HEX_LO, RESPOND.
- A byte is accepted on any cycle with `rx_valid && rx_ready`.
- `rx_ready` = 1 in IDLE, HEX_HI and HEX_LO; 0 in RESPOND and during reset.

IDLE decode (values are ASCII):
- `d`: if `dump_busy`=0, pulse `dump_start` and respond `+`; otherwise respond `?` with no pulse.
- `r`: set `record_start`=1; respond `+`.
- `s`: set `record_start`=0; respond `+`.
- `t`: pulse `record_trigger`; respond `+`.
- `x`: load the reset counter with `RESET_CYCLES`; respond `+`. A new `x` while the counter is running reloads it.
- `n`: go to HEX_HI; no response yet.
- 0x0D, 0x0A, 0x20: discarded silently; stay in IDLE.
- Any other byte: respond `?`.

Hex entry:
- HEX_HI accepts `0`-`9`, `a`-`f`, `A`-`F` and latches the high nibble, then goes to HEX_LO.
- HEX_LO accepts the same set; `record_limit` <= {hi, lo}; respond `+`.
- A non-hex byte in HEX_HI or HEX_LO: respond `?`; `record_limit` unchanged.
- Timeout: a cycle counter clears on entry to HEX_HI and on every accepted byte, and increments every cycle in HEX_HI/HEX_LO.
- When the counter reaches `TIMEOUT_CYCLES-1`: respond `?`, go to IDLE, `record_limit` unchanged.

RESPOND:
- `tx_valid`=1 and `tx_data` held stable until `tx_valid && tx_ready`, then go to IDLE.
- Commands are never queued; one response is outstanding at most.

## Timing
- Reset values: `rx_ready`=0, `tx_valid`=0, `tx_data`=0x00, `dump_start`=0, `record_start`=1, `record_trigger`=0, `record_limit`=0x00, `bus_reset`=0, state IDLE.
- All counters clear on reset.
- All outputs are registered.
- Acceptance on cycle N gives:
  - action outputs (`dump_start`/`record_trigger` pulse, `record_start` change, `record_limit` update, `bus_reset` rise) in cycle N+1;
  - `tx_valid`=1 in cycle N+1.
- If `tx_ready`=1 in N+1, the response completes and `rx_ready`=1 in N+2. Throughput is one command per 2 cycles.
- `dump_start` and `record_trigger` are exactly 1 cycle wide.
- `bus_reset` is high for exactly `RESET_CYCLES` consecutive cycles, counted from N+1 after the last `x`.
- `bus_reset` runs independently of the FSM; commands are still decoded while it is high.
- `reset` asserted mid-operation:
  - abandons any pending response (`tx_valid` drops the next cycle);
  - aborts hex entry;
  - forces all reset values;
  - terminates `bus_reset` immediately.
- `dump_busy` is sampled only on the cycle the `d` byte is accepted.

## Test plan
- Reset, then send `r`, `s`, `t` with `tx_ready`=1.
  - After reset: `record_start`=1.
  - After `s`: `record_start`=0.
  - After `t`: one `record_trigger` pulse, and the TX bytes are `+`,`+`,`+`.
- Send `d` with `dump_busy`=0, then `d` with `dump_busy`=1.
  - First: exactly one `dump_start` pulse.
  - Second: no pulse, TX byte `?`.
- Send `n`,`3`,`F`.
  - `record_limit`=0x3F, TX `+`.
  - Then `n`,`g`: `record_limit` stays 0x3F, TX `?`.
- Send `n`,`A`, then wait `TIMEOUT_CYCLES` (override to 20) with no bytes.
  - TX `?` after 20 idle cycles; FSM back in IDLE; `record_limit` unchanged.
- Send `x` (`RESET_CYCLES`=16); resend `x` 10 cycles later.
  - `bus_reset` is high for 26 consecutive cycles total.
  - `\r`/`\n` between commands produce no TX byte.
- Hold `tx_ready`=0 for 50 cycles after a `t`.
  - `tx_valid` and `tx_data`=`+` stay stable and `rx_ready`=0 throughout.
  - Asserting `reset` mid-wait drops `tx_valid` and restores `record_start`=1.
